audio_energy_multi: RTL and testbench
=====================================

Name: audio_energy_multi

Overview:
- Parametrised multi-channel successor to the single-mic amplitude integrator.
- Accepts one packed sample word per `ready` strobe from the AC97 front end, covering all mic channels.
- Accumulates squared magnitudes per channel over a fixed window, then publishes thresholded, scaled energy per channel plus the index of the loudest channel.
- Feeds the tracking/direction logic. One shared squarer is time-multiplexed across channels under a small FSM.

Parameters:
- CHANNELS, 2, number of mic channels (1..8)
- SAMPLE_W, 8, signed sample width per channel
- WINDOW, 800, samples per integration window (>=2)
- SHIFT, 6, right shift applied to each square before accumulation
- ACC_W, 18, accumulator width per channel
- OUT_SHIFT, 2, right shift from accumulator to output scale
- MULTIPLY, 1, output gain
- THRESHOLD, 5000, gated outputs at or below this value read 0

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ready  in  1  one-cycle sample strobe from ac97
- audio_in  in  CHANNELS*SAMPLE_W  packed signed samples; channel k at [k*SAMPLE_W +: SAMPLE_W]
- amplitude  out  CHANNELS*16  per-channel gated energy; channel k at [k*16 +: 16]
- loudest  out  3  index of the channel with the largest amplitude
- done  out  1  one-cycle pulse when amplitude/loudest update
- busy  out  1  high whenever FSM is not IDLE
- overrun  out  1  sticky; set when `ready` arrives while busy

Behaviour:
- Reset (async, reset_n=0): all outputs 0, accumulators 0, sample counter 0, FSM to IDLE.
- FSM states: IDLE, MAC, DUMP.
- IDLE:
  - On `ready`: latch audio_in into the sample register, set ch_idx=0, go to MAC.
  - Otherwise stay.
- MAC (exactly CHANNELS cycles, one channel per cycle):
  - mag = |sample[ch_idx]|. Most negative code -2^(SAMPLE_W-1) maps to 2^(SAMPLE_W-1); no wrap.
  - sq = (mag*mag) >> SHIFT.
  - acc[ch_idx] <= acc[ch_idx] + sq, saturating at 2^ACC_W-1.
  - After the last channel, increment the sample counter.
  - If the counter reaches WINDOW (i.e. that was the WINDOW-th sample): go to DUMP. Otherwise go to IDLE.
- DUMP (1 cycle), per channel:
  - v = (acc >> OUT_SHIFT) * MULTIPLY, saturated to 65535.
  - amplitude_k <= (v > THRESHOLD) ? v : 0.
- DUMP (1 cycle), common actions:
  - Clear all accumulators and the sample counter.
  - `loudest` <= index of the maximum gated amplitude; lowest index wins ties; all-zero gives 0.
  - `done` <= 1 for the following cycle only; go to IDLE.
- Latency:
  - `ready` sampled at edge t: MAC occupies edges t+1..t+CHANNELS.
  - Non-window sample: back in IDLE after edge t+CHANNELS.
  - Window-ending sample: DUMP at edge t+CHANNELS+1; `done` and new amplitudes visible from t+CHANNELS+1.
- Minimum `ready` spacing:
  - CHANNELS+1 cycles; CHANNELS+2 on the window-ending sample.
  - AC97 rate (~48 kHz at 27 MHz) is far above this limit.
- `ready` while busy: sample dropped, counter unaffected, `overrun` set. `overrun` is cleared only by reset.
- amplitude/loudest hold their values between DUMPs.
- Reset mid-window discards the partial window; the next window starts from zero.

Optional Feature:
- Macro: AUDIO_ENERGY_PEAK_EN.
- When defined:
  - Adds output port `peak` (CHANNELS*SAMPLE_W).
  - Tracks the per-channel maximum of mag during MAC.
  - Latches it to `peak` at DUMP, then clears the trackers.
  - Reset value 0.
  - Peak values are not thresholded.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults; ch0=+64, ch1=0 for 800 strobes (spacing 10) -> one `done` pulse; amplitude0=12800, amplitude1=0, loudest=0.
- ch0=-128, ch1=+32 for 800 strobes -> amplitude0=51200; amplitude1=0 (3200 <= THRESHOLD); loudest=0. Confirms no wrap on the most negative code.
- MULTIPLY=2, ch1=-128 for 800 strobes -> amplitude1=65535 (saturated); loudest=1.
- Both channels=+64 -> amplitude0=amplitude1=12800; loudest=0 (tie rule).
- `ready` held high 2 consecutive cycles -> only the first sample counted; `overrun`=1 and stays set; `done` appears after 800 accepted samples, not 800 strobes.
- reset_n pulsed low after 400 samples of +64 -> all outputs 0 immediately (async); next 800 samples of +64 yield amplitude0=12800. With AUDIO_ENERGY_PEAK_EN: peak0=64.

Source files
------------

// File: rtl/audio_energy_multi.sv
`default_nettype none
// ============================================================================
// Module   : audio_energy_multi
// Purpose  : Multi-channel windowed audio energy integrator. One shared
//            squarer is time-multiplexed across channels by a small FSM.
//            Publishes thresholded, scaled energy per channel plus the
//            index of the loudest channel once per window.
// Options  : define AUDIO_ENERGY_PEAK_EN to add the per-channel `peak` output.
// Revision : 1.0 - initial release
// ============================================================================
module audio_energy_multi #(
  parameter int CHANNELS  = 2,
  parameter int SAMPLE_W  = 8,
  parameter int WINDOW    = 800,
  parameter int SHIFT     = 6,
  parameter int ACC_W     = 18,
  parameter int OUT_SHIFT = 2,
  parameter int MULTIPLY  = 1,
  parameter int THRESHOLD = 5000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
  output logic [CHANNELS*16-1:0]       amplitude,
  output logic [2:0]                   loudest,
  output logic                         done,
  output logic                         busy,
  output logic                         overrun
`ifdef AUDIO_ENERGY_PEAK_EN
  ,
  output logic [CHANNELS*SAMPLE_W-1:0] peak
`endif
);

  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int SQ_W   = 2 * SAMPLE_W;
  localparam int SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int PROD_W = ACC_W + 32;
  localparam logic [IDX_W-1:0] C_LAST_CH = IDX_W'(CHANNELS - 1);
  localparam logic [ACC_W-1:0] C_ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DUMP = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [CHANNELS*SAMPLE_W-1:0] r_sample;
  logic [IDX_W-1:0]             r_ch_idx;
  logic [CNT_W-1:0]             r_count;
  logic [ACC_W-1:0]             r_acc [CHANNELS];
  logic [CHANNELS*16-1:0]       r_amp;
  logic [2:0]                   r_loudest;
  logic                         r_done;
  logic                         r_overrun;

  logic [SAMPLE_W-1:0] w_cur;
  logic [SAMPLE_W-1:0] w_mag;
  logic [SQ_W-1:0]     w_sq;
  logic [SUM_W-1:0]    w_sum;
  logic [ACC_W-1:0]    w_acc_next;
  logic [CNT_W-1:0]    w_count_inc;
  logic                w_last_ch;
  logic                w_window_end;
  logic [PROD_W-1:0]   w_prod  [CHANNELS];
  logic [15:0]         w_gated [CHANNELS];
  logic [15:0]         w_best;
  logic [2:0]          w_loudest;

  // Magnitude of the channel currently selected; the most negative code
  // becomes 2^(SAMPLE_W-1) because the result is read as unsigned.
  assign w_cur        = r_sample[r_ch_idx*SAMPLE_W +: SAMPLE_W];
  assign w_mag        = w_cur[SAMPLE_W-1] ? (~w_cur + 1'b1) : w_cur;
  assign w_sq         = (SQ_W'(w_mag) * SQ_W'(w_mag)) >> SHIFT;
  assign w_sum        = SUM_W'(r_acc[r_ch_idx]) + SUM_W'(w_sq);
  assign w_acc_next   = (w_sum > SUM_W'(C_ACC_MAX)) ? C_ACC_MAX : w_sum[ACC_W-1:0];
  assign w_count_inc  = r_count + 1'b1;
  assign w_last_ch    = (r_ch_idx == C_LAST_CH);
  assign w_window_end = (w_count_inc == CNT_W'(WINDOW));

  // Scale, saturate and gate each accumulator for publication.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_prod[k]  = PROD_W'(r_acc[k] >> OUT_SHIFT) * PROD_W'(MULTIPLY);
      w_gated[k] = 16'd0;
      if (w_prod[k] > PROD_W'(65535)) begin
        w_gated[k] = 16'hFFFF;
      end else if (w_prod[k] > PROD_W'(THRESHOLD)) begin
        w_gated[k] = w_prod[k][15:0];
      end
    end
  end

  // Loudest channel: strict greater-than so the lowest index wins ties.
  always_comb begin
    w_loudest = 3'd0;
    w_best    = w_gated[0];
    for (int k = 1; k < CHANNELS; k++) begin
      if (w_gated[k] > w_best) begin
        w_best    = w_gated[k];
        w_loudest = 3'(k);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next-state decode and busy flag.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (ready) w_state_next = S_MAC;
      S_MAC:  if (w_last_ch) w_state_next = w_window_end ? S_DUMP : S_IDLE;
      S_DUMP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: sample capture, accumulation, window dump and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sample  <= '0;
      r_ch_idx  <= '0;
      r_count   <= '0;
      r_amp     <= '0;
      r_loudest <= 3'd0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
    end else begin
      r_done <= (r_state == S_DUMP);
      if (ready && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_sample <= audio_in;
            r_ch_idx <= '0;
          end
        end
        S_MAC: begin
          r_acc[r_ch_idx] <= w_acc_next;
          r_ch_idx        <= r_ch_idx + 1'b1;
          if (w_last_ch) r_count <= w_count_inc;
        end
        S_DUMP: begin
          for (int k = 0; k < CHANNELS; k++) begin
            r_amp[k*16 +: 16] <= w_gated[k];
            r_acc[k]          <= '0;
          end
          r_loudest <= w_loudest;
          r_count   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign amplitude = r_amp;
  assign loudest   = r_loudest;
  assign done      = r_done;
  assign overrun   = r_overrun;

`ifdef AUDIO_ENERGY_PEAK_EN
  logic [SAMPLE_W-1:0]          r_pk [CHANNELS];
  logic [CHANNELS*SAMPLE_W-1:0] r_peak;

  // Per-channel peak magnitude tracking, published and cleared at dump.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_peak <= '0;
      for (int k = 0; k < CHANNELS; k++) r_pk[k] <= '0;
    end else if (r_state == S_MAC) begin
      if (w_mag > r_pk[r_ch_idx]) r_pk[r_ch_idx] <= w_mag;
    end else if (r_state == S_DUMP) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_peak[k*SAMPLE_W +: SAMPLE_W] <= r_pk[k];
        r_pk[k]                        <= '0;
      end
    end
  end

  assign peak = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_energy_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_energy_multi
// Purpose  : Scoreboard bench for audio_energy_multi. Two instances share
//            stimulus: default gain and MULTIPLY=2. Expected window results
//            are queued as stimulus is driven and checked on each `done`.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_energy_multi;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ready = 1'b0;
  logic [15:0] audio_in = 16'd0;

  logic [31:0] amp1, amp2;
  logic [2:0]  loud1, loud2;
  logic        done1, done2, busy1, busy2, ovr1, ovr2;
`ifdef AUDIO_ENERGY_PEAK_EN
  logic [15:0] peak1, peak2;
`endif

  always #5 clock = ~clock;

  audio_energy_multi u_dut1 (
    .clock(clock), .reset_n(reset_n), .ready(ready), .audio_in(audio_in),
    .amplitude(amp1), .loudest(loud1), .done(done1), .busy(busy1), .overrun(ovr1)
`ifdef AUDIO_ENERGY_PEAK_EN
    , .peak(peak1)
`endif
  );

  audio_energy_multi #(.MULTIPLY(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .ready(ready), .audio_in(audio_in),
    .amplitude(amp2), .loudest(loud2), .done(done2), .busy(busy2), .overrun(ovr2)
`ifdef AUDIO_ENERGY_PEAK_EN
    , .peak(peak2)
`endif
  );

  typedef struct {
    int a0;
    int a1;
    int l;
    int p0;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int a0, input int a1, input int l, input int p0,
                      input int b0, input int b1, input int bl);
    exp_t e;
    e.a0 = a0; e.a1 = a1; e.l = l;  e.p0 = p0;
    q1.push_back(e);
    e.a0 = b0; e.a1 = b1; e.l = bl; e.p0 = p0;
    q2.push_back(e);
  endtask

  // n strobes of (ch0=s0, ch1=s1); dbl holds ready for a second cycle with
  // a different word that must be dropped.
  task automatic drive(input int s0, input int s1, input int n, input bit dbl);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      audio_in = {8'(s1), 8'(s0)};
      ready    = 1'b1;
      @(posedge clock); #1;
      if (i == 0) check("busy_after_ready", int'(busy1), 1);
      if (dbl) begin
        audio_in = 16'h8080;
        @(posedge clock); #1;
      end
      ready = 1'b0;
      repeat (7) @(posedge clock);
    end
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && (q1.size() + q2.size()) > 0; k++) @(posedge clock);
    check(tag, q1.size() + q2.size(), 0);
  endtask

  // Scoreboard for the default-gain instance.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("unexpected_done1", int'(done1), 0);
      end else begin
        e1 = q1.pop_front();
        check("d1_amp0", int'(amp1[15:0]), e1.a0);
        check("d1_amp1", int'(amp1[31:16]), e1.a1);
        check("d1_loudest", int'(loud1), e1.l);
`ifdef AUDIO_ENERGY_PEAK_EN
        check("d1_peak0", int'(peak1[7:0]), e1.p0);
`endif
      end
    end
  end

  // Scoreboard for the MULTIPLY=2 instance.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        check("unexpected_done2", int'(done2), 0);
      end else begin
        e2 = q2.pop_front();
        check("d2_amp0", int'(amp2[15:0]), e2.a0);
        check("d2_amp1", int'(amp2[31:16]), e2.a1);
        check("d2_loudest", int'(loud2), e2.l);
`ifdef AUDIO_ENERGY_PEAK_EN
        check("d2_peak0", int'(peak2[7:0]), e2.p0);
`endif
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_amp1", int'(amp1), 0);
    check("rst_loud1", int'(loud1), 0);
    check("rst_done1", int'(done1), 0);
    check("rst_busy1", int'(busy1), 0);
    check("rst_ovr1", int'(ovr1), 0);
    check("rst_amp2", int'(amp2), 0);
    check("rst_busy2", int'(busy2), 0);
    check("rst_ovr2", int'(ovr2), 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single loud channel.
    push(12800, 0, 0, 64,   25600, 0, 0);
    drive(64, 0, 800, 1'b0);
    drain("drain_w1");

    // Most negative code without wrap; ch1 below threshold at unity gain.
    push(51200, 0, 0, 128,  65535, 6400, 0);
    drive(-128, 32, 800, 1'b0);
    drain("drain_w2");

    // Loud channel 1; saturation at gain 2.
    push(0, 51200, 1, 0,    0, 65535, 1);
    drive(0, -128, 800, 1'b0);
    drain("drain_w3");

    // Equal channels: lowest index wins.
    push(12800, 12800, 0, 64, 25600, 25600, 0);
    drive(64, 64, 800, 1'b0);
    drain("drain_w4");
    check("ovr_before", int'(ovr1), 0);

    // Every strobe held two cycles: only the first word counts.
    push(0, 12800, 1, 32,   6400, 25600, 1);
    drive(32, 64, 800, 1'b1);
    drain("drain_w5");
    check("ovr1_set", int'(ovr1), 1);
    check("ovr2_set", int'(ovr2), 1);

    // Partial window then asynchronous reset mid-cycle.
    drive(64, 0, 400, 1'b0);
    check("ovr_sticky", int'(ovr1), 1);
    @(posedge clock); #3 reset_n = 1'b0;
    #1;
    check("arst_amp1", int'(amp1), 0);
    check("arst_loud1", int'(loud1), 0);
    check("arst_ovr1", int'(ovr1), 0);
    check("arst_busy1", int'(busy1), 0);
    check("arst_amp2", int'(amp2), 0);
    check("arst_ovr2", int'(ovr2), 0);
`ifdef AUDIO_ENERGY_PEAK_EN
    check("arst_peak1", int'(peak1), 0);
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Fresh window after reset must not include the discarded samples.
    push(12800, 0, 0, 64,   25600, 0, 0);
    drive(64, 0, 800, 1'b0);
    drain("drain_w7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
